// File: rtl/mtimer_pkg.sv
// Shared constants and types for the machine-timer controller.
package mtimer_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned DIV_W_DEF = 8;

  localparam logic [2:0] MTIME_LO_A    = 3'd0;
  localparam logic [2:0] MTIME_HI_A    = 3'd1;
  localparam logic [2:0] MTIMECMP_LO_A = 3'd2;
  localparam logic [2:0] MTIMECMP_HI_A = 3'd3;
  localparam logic [2:0] CTRL_A        = 3'd4;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_DIV_LSB = 8;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } bus_state_t;

  localparam logic [XLEN_DEF-1:0] MTIMECMP_RST = '1;

endpackage

// File: rtl/mtimer_ctrl_counter.sv
// Generic up-counter with synchronous load; load takes priority over increment.
module counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] count_in,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= count_in;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mtimer_ctrl.sv
// Machine-timer controller: 64-bit mtime from two counter halves, prescaler,
// mtimecmp compare and a req/ack register port.
module mtimer_ctrl
  import mtimer_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic            we,
  input  logic [2:0]      addr,
  input  logic [XLEN-1:0] wdata,
  output logic            ack,
  output logic [XLEN-1:0] rdata,
  output logic            timer_irq
);

  bus_state_t state_q, state_d;

  logic [XLEN-1:0]  mtime_lo, mtime_hi;
  logic [XLEN-1:0]  cmp_lo, cmp_hi, hi_shadow;
  logic             en;
  logic [DIV_W-1:0] div, pcnt;

  logic             access, wr_lo, wr_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, rd_lo;
  logic             tick, lo_carry, irq_cond;
  logic             ack_d;
  logic [XLEN-1:0]  rdata_d, read_val, ctrl_val;

  // Access decode: only a request seen in IDLE has any effect.
  always_comb begin
    access    = (state_q == IDLE) && req;
    wr_lo     = 1'b0;
    wr_hi     = 1'b0;
    wr_cmp_lo = 1'b0;
    wr_cmp_hi = 1'b0;
    wr_ctrl   = 1'b0;
    rd_lo     = 1'b0;
    if (access && we) begin
      wr_lo     = (addr == MTIME_LO_A);
      wr_hi     = (addr == MTIME_HI_A);
      wr_cmp_lo = (addr == MTIMECMP_LO_A);
      wr_cmp_hi = (addr == MTIMECMP_HI_A);
      wr_ctrl   = (addr == CTRL_A);
    end
    if (access && !we) begin
      rd_lo = (addr == MTIME_LO_A);
    end
  end

  always_comb begin
    ctrl_val                             = '0;
    ctrl_val[CTRL_EN_BIT]                = en;
    ctrl_val[CTRL_DIV_LSB +: DIV_W]      = div;
    read_val                             = '0;
    case (addr)
      MTIME_LO_A:    read_val = mtime_lo;
      MTIME_HI_A:    read_val = hi_shadow;
      MTIMECMP_LO_A: read_val = cmp_lo;
      MTIMECMP_HI_A: read_val = cmp_hi;
      CTRL_A:        read_val = ctrl_val;
      default:       read_val = '0;
    endcase
  end

  // Bus FSM next state and registered-output values.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = ACK;
          ack_d   = 1'b1;
          if (!we) rdata_d = read_val;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ack     <= 1'b0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      ack     <= ack_d;
      rdata   <= rdata_d;
    end
  end

  // Prescaler wraps via load-to-zero; a CTRL write also restarts it.
  assign tick     = en && (pcnt == div);
  assign lo_carry = tick && (&mtime_lo) && !wr_lo;

  counter #(.WIDTH(DIV_W)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable   (en),
    .load     (wr_ctrl || tick),
    .count_in ('0),
    .count    (pcnt)
  );

  counter #(.WIDTH(XLEN)) u_mtime_lo (
    .clk      (clk),
    .reset    (reset),
    .enable   (tick),
    .load     (wr_lo),
    .count_in (wdata),
    .count    (mtime_lo)
  );

  counter #(.WIDTH(XLEN)) u_mtime_hi (
    .clk      (clk),
    .reset    (reset),
    .enable   (lo_carry),
    .load     (wr_hi),
    .count_in (wdata),
    .count    (mtime_hi)
  );

  assign irq_cond = {mtime_hi, mtime_lo} >= {cmp_hi, cmp_lo};

  // Configuration, snapshot and interrupt flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_lo    <= XLEN'(MTIMECMP_RST);
      cmp_hi    <= XLEN'(MTIMECMP_RST);
      en        <= 1'b0;
      div       <= '0;
      hi_shadow <= '0;
      timer_irq <= 1'b0;
    end else begin
      if (wr_cmp_lo) cmp_lo <= wdata;
      if (wr_cmp_hi) cmp_hi <= wdata;
      if (wr_ctrl) begin
        en  <= wdata[CTRL_EN_BIT];
        div <= wdata[CTRL_DIV_LSB +: DIV_W];
      end
      if (wr_hi) begin
        hi_shadow <= wdata;
      end else if (rd_lo) begin
        hi_shadow <= mtime_hi;
      end
      timer_irq <= irq_cond;
    end
  end

endmodule
